// File: rtl/proc_ctrl_pkg.sv
// Shared types and defaults for the processor run controller.
// Optional cycle counter is enabled with PROC_RUN_CYCLE_COUNT_EN.
package proc_ctrl_pkg;

    localparam int DEF_XLEN       = 64;
    localparam int DEF_WDOG_LIMIT = 255;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        CHECK,
        DONE
    } run_state_t;

endpackage

// File: rtl/run_watchdog.sv
// Saturating RUN-cycle watchdog with an optional cycle counter.
// The counter is built only when PROC_RUN_CYCLE_COUNT_EN is defined.
module run_watchdog
    import proc_ctrl_pkg::*;
#(
    parameter int WDOG_W     = 16,
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              run,
    input  logic              stop,
    output logic              expired,
    output logic [WDOG_W-1:0] count
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] wdog_q;

    // Parks at LAST; the controller leaves RUN on that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (clr) begin
            wdog_q <= '0;
        end else if (run && !stop && !expired) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    assign expired = (wdog_q == LAST);

`ifdef PROC_RUN_CYCLE_COUNT_EN
    logic [WDOG_W-1:0] cyc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else if (clr) begin
            cyc_q <= '0;
        end else if (run && cyc_q != '1) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign count = cyc_q;
`else
    assign count = '0;
`endif

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: resets the core, releases it, watches for end PC or
// watchdog expiry and grades the result. Macro: PROC_RUN_CYCLE_COUNT_EN.
module proc_run_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int XLEN         = DEF_XLEN,
    parameter int RESET_CYCLES = 2,
    parameter int WDOG_W       = 16,
    parameter int WDOG_LIMIT   = DEF_WDOG_LIMIT
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [XLEN-1:0]   cfg_startpc,
    input  logic [XLEN-1:0]   cfg_endpc,
    input  logic [XLEN-1:0]   cfg_expected,
    input  logic [XLEN-1:0]   currentpc,
    input  logic [XLEN-1:0]   MemtoRegOut,
    output logic              proc_resetl,
    output logic [XLEN-1:0]   proc_startpc,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [XLEN-1:0]   result,
    output logic [WDOG_W-1:0] cycle_count
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

    run_state_t      state_q, state_n;
    logic [HW-1:0]   hold_q;
    logic [XLEN-1:0] endpc_q;
    logic [XLEN-1:0] expected_q;
    logic            start_ok;
    logic            end_hit;
    logic            wd_expired;

    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign end_hit  = (currentpc >= endpc_q);

    run_watchdog #(
        .WDOG_W    (WDOG_W),
        .WDOG_LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk    (CLK),
        .rst    (reset),
        .clr    (start_ok),
        .run    (state_q == RUN),
        .stop   (end_hit),
        .expired(wd_expired),
        .count  (cycle_count)
    );

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_n = HOLD;
            HOLD:       if (hold_q == HOLD_LAST) state_n = RUN;
            RUN: begin
                // End PC takes priority over a coincident timeout.
                if (end_hit)         state_n = CHECK;
                else if (wd_expired) state_n = DONE;
            end
            CHECK:      state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_n;
            hold_q  <= (state_q == HOLD) ? hold_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            proc_startpc <= '0;
            endpc_q      <= '0;
            expected_q   <= '0;
        end else if (start_ok) begin
            proc_startpc <= cfg_startpc;
            endpc_q      <= cfg_endpc;
            expected_q   <= cfg_expected;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pass    <= 1'b0;
            timeout <= 1'b0;
            result  <= '0;
        end else if (start_ok) begin
            pass    <= 1'b0;
            timeout <= 1'b0;
            result  <= '0;
        end else if (state_q == CHECK) begin
            result <= MemtoRegOut;
            pass   <= (MemtoRegOut == expected_q);
        end else if (state_q == RUN && !end_hit && wd_expired) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
        end
    end

    // Status flags are decoded from the next state so they stay registered.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            proc_resetl <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            proc_resetl <= state_n inside {RUN, CHECK, DONE};
            busy        <= state_n inside {HOLD, RUN, CHECK};
            done        <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboarded bench for proc_run_ctrl with a behavioural processor model.
module tb_proc_run_ctrl;

    localparam int XLEN = 64;
    localparam int RC   = 2;
    localparam int WW   = 16;
    localparam int WL   = 255;
    localparam logic [63:0] MAGIC = 64'h1234_5678_9abc_def0;

    typedef struct packed {
        logic        pass;
        logic        timeout;
        logic [63:0] result;
        logic [15:0] cc;
    } exp_t;

    logic          CLK = 1'b0;
    logic          reset;
    logic          start;
    logic [63:0]   cfg_startpc, cfg_endpc, cfg_expected;
    logic [63:0]   currentpc, MemtoRegOut;
    logic          proc_resetl;
    logic [63:0]   proc_startpc;
    logic          busy, done, pass, timeout;
    logic [63:0]   result;
    logic [WW-1:0] cycle_count;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    exp_t mon_e;
    logic done_prev = 1'b0;

    logic        stuck = 1'b0;
    logic [63:0] pc_m = '0;
    logic [63:0] mem_m = '0;

    always #5 CLK = ~CLK;

    proc_run_ctrl #(
        .XLEN(XLEN), .RESET_CYCLES(RC), .WDOG_W(WW), .WDOG_LIMIT(WL)
    ) dut (
        .CLK(CLK), .reset(reset), .start(start),
        .cfg_startpc(cfg_startpc), .cfg_endpc(cfg_endpc),
        .cfg_expected(cfg_expected), .currentpc(currentpc),
        .MemtoRegOut(MemtoRegOut), .proc_resetl(proc_resetl),
        .proc_startpc(proc_startpc), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .result(result),
        .cycle_count(cycle_count)
    );

    function automatic logic [63:0] f(input logic [63:0] p);
        if (p == 64'h54) return MAGIC;
        if (p[11:8] != 4'd0) return p * 64'h9E37_79B9_7F4A_7C15;
        return p;
    endfunction

    // Processor: PC held at start PC in reset, else steps by 4;
    // writeback value lags the PC by one cycle.
    always @(posedge CLK) begin
        if (!proc_resetl) pc_m <= proc_startpc;
        else if (stuck)   pc_m <= 64'h10;
        else              pc_m <= pc_m + 64'd4;
        mem_m <= f(pc_m);
    end

    assign currentpc   = pc_m;
    assign MemtoRegOut = mem_m;

    // Reference: step the program PC until it reaches endpc or the
    // watchdog allowance of WL RUN cycles is used up.
    function automatic exp_t ref_run(input logic [63:0] spc, epc, ex,
                                     input logic stk);
        exp_t e;
        logic [63:0] p;
        int k;
        p = spc;
        k = -1;
        for (int i = 0; i < WL; i++) begin
            if (p >= epc) begin
                k = i;
                break;
            end
            p = stk ? 64'h10 : p + 64'd4;
        end
        if (k >= 0) begin
            e.result  = f(p);
            e.pass    = (e.result == ex);
            e.timeout = 1'b0;
            e.cc      = 16'(k + 1);
        end else begin
            e.result  = '0;
            e.pass    = 1'b0;
            e.timeout = 1'b1;
            e.cc      = 16'(WL);
        end
`ifndef PROC_RUN_CYCLE_COUNT_EN
        e.cc = '0;
`endif
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!reset && done && !done_prev) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pass", 64'(pass), 64'(mon_e.pass));
                check("timeout", 64'(timeout), 64'(mon_e.timeout));
                check("result", result, mon_e.result);
                check("cycle_count", 64'(cycle_count), 64'(mon_e.cc));
                check("busy_in_done", 64'(busy), 64'd0);
            end
        end
        done_prev <= done;
    end

    task automatic run(input logic [63:0] spc, epc, ex,
                       input logic stk, input logic disturb);
        int low;
        int n;
        low = 0;
        n = 0;
        @(negedge CLK);
        stuck        = stk;
        cfg_startpc  = spc;
        cfg_endpc    = epc;
        cfg_expected = ex;
        start        = 1'b1;
        sb.push_back(ref_run(spc, epc, ex, stk));
        @(negedge CLK);
        start = 1'b0;
        check("done_cleared", 64'(done), 64'd0);
        check("hold_startpc", proc_startpc, spc);
        while (!done && n < 600) begin
            if (!proc_resetl) low++;
            if (disturb) begin
                cfg_startpc  = {$urandom, $urandom};
                cfg_endpc    = {$urandom, $urandom};
                cfg_expected = {$urandom, $urandom};
                start        = busy && ($urandom_range(0, 3) == 0);
            end
            @(negedge CLK);
            n++;
        end
        start = 1'b0;
        if (!done) check("run_bound", 64'(done), 64'd1);
        else       check("resetl_low_cycles", 64'(low), 64'(RC));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_resetl"}, 64'(proc_resetl), 64'd0);
        check({tag, "_startpc"}, proc_startpc, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_result"}, result, 64'd0);
        check({tag, "_cc"}, 64'(cycle_count), 64'd0);
    endtask

    initial begin
        logic [63:0] spc, epc, ex;
        exp_t pe;
        int r;
        reset = 1'b1;
        start = 1'b0;
        cfg_startpc  = '0;
        cfg_endpc    = '0;
        cfg_expected = '0;
        #12;
        check_reset_vals("por");
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check("idle_busy", 64'(busy), 64'd0);

        run(64'h0, 64'h30, 64'h30, 1'b0, 1'b0);
`ifdef PROC_RUN_CYCLE_COUNT_EN
        check("t1_cycles", 64'(cycle_count), 64'd13);
`else
        check("t1_cycles", 64'(cycle_count), 64'd0);
`endif
        run(64'h0, 64'h30, 64'hF, 1'b0, 1'b0);
        check("t2_result", result, 64'h30);
        check("t2_pass", 64'(pass), 64'd0);
        run(64'h10, 64'h54, 64'h0, 1'b1, 1'b0);
        check("t3_timeout", 64'(timeout), 64'd1);
        run(64'h0, 64'h30, 64'h30, 1'b0, 1'b0);
        run(64'h30, 64'h54, MAGIC, 1'b0, 1'b0);
        check("t4_pass", 64'(pass), 64'd1);
        run(64'h0, 64'h80, f(64'h80), 1'b0, 1'b1);

        @(negedge CLK);
        cfg_startpc  = 64'h100;
        cfg_endpc    = 64'h400;
        cfg_expected = 64'h0;
        start        = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_resetl", 64'(proc_resetl), 64'd1);
        #2 reset = 1'b1;
        #1 check_reset_vals("async");
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check("post_reset_busy", 64'(busy), 64'd0);
        run(64'h100, 64'h140, f(64'h140), 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            spc = 64'($urandom_range(0, 1023)) * 64'd4;
            r = $urandom_range(0, 9);
            if (r == 0)      epc = 64'($urandom_range(0, int'(spc)));
            else if (r == 1) epc = spc + 64'd1600;
            else             epc = spc + 64'($urandom_range(1, 300));
            pe = ref_run(spc, epc, 64'd0, 1'b0);
            ex = $urandom_range(0, 1) ? pe.result : {$urandom, $urandom};
            run(spc, epc, ex, 1'b0, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge CLK);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
